pb_debounce: RTL and testbench

Conditions the raw, asynchronous push-button inputs before they reach the CPU core. It sits between the board pins and the core's button inputs, in the same clock/reset domain as the core. Per button it does three things:
- 2-flop synchronization
- time-based debounce (state machine plus counter)
- one-cycle press/release pulses alongside the clean level

---
 rtl/pb_debounce_if.sv | 28 ++
 rtl/pb_debounce.sv | 123 ++++++++++++
 tb/tb_pb_debounce.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pb_debounce_if.sv
// Push-button bundle between the board-pin side and the debouncer.
//   pb_in      : raw asynchronous button levels, 1 = pressed
//   pb_level   : debounced level, registered
//   pb_press   : one-clock pulse per accepted 0->1 transition
//   pb_release : one-clock pulse per accepted 1->0 transition
// master = pin/stimulus side, slave = debouncer.
interface pb_debounce_if #(
  parameter int unsigned N = 5
);
  logic [N-1:0] pb_in;
  logic [N-1:0] pb_level;
  logic [N-1:0] pb_press;
  logic [N-1:0] pb_release;

  modport master (
    output pb_in,
    input  pb_level,
    input  pb_press,
    input  pb_release
  );

  modport slave (
    input  pb_in,
    output pb_level,
    output pb_press,
    output pb_release
  );
endinterface

// File: rtl/pb_debounce.sv
// Push-button conditioner: per channel a 2-flop synchronizer, a time-based
// debounce FSM with a qualification counter, and registered press/release
// pulses next to the clean level.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : pb_debounce_if slave (pb_in in; pb_level/pb_press/pb_release out)
// Parameters:
//   N             : number of independent channels
//   STABLE_CYCLES : clocks a new synchronized value must hold (2..2^CNT_W)
//   CNT_W         : per-channel counter width, 2^CNT_W >= STABLE_CYCLES
module pb_debounce #(
  parameter int unsigned N             = 5,
  parameter int unsigned STABLE_CYCLES = 100000,
  parameter int unsigned CNT_W         = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  pb_debounce_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_LO      = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_HI      = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  // Terminal count; reaching it while still waiting accepts the new level,
  // so the counter never needs to go past STABLE_CYCLES-1 and cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [N-1:0]     s1_q;
  logic [N-1:0]     s2_q;
  state_t           state_q [N];
  state_t           state_d [N];
  logic [CNT_W-1:0] cnt_q   [N];
  logic [CNT_W-1:0] cnt_d   [N];
  logic [N-1:0]     level_q;
  logic [N-1:0]     press_q;
  logic [N-1:0]     release_q;
  logic [N-1:0]     level_d;
  logic [N-1:0]     press_d;
  logic [N-1:0]     release_d;

  // Two-flop synchronizer; only s2_q is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.pb_in;
      s2_q <= s1_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        state_q[i] <= ST_LO;
        cnt_q[i]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next state; the counter defaults to 0, which both clears it on every
  // WAIT entry and holds it at 0 in the stable states.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      case (state_q[i])
        ST_LO: begin
          if (s2_q[i]) state_d[i] = ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (!s2_q[i])                  state_d[i] = ST_LO;
          else if (cnt_q[i] == CNT_LAST) state_d[i] = ST_HI;
          else                           cnt_d[i]   = cnt_q[i] + CNT_W'(1);
        end
        ST_HI: begin
          if (!s2_q[i]) state_d[i] = ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (s2_q[i])                   state_d[i] = ST_HI;
          else if (cnt_q[i] == CNT_LAST) state_d[i] = ST_LO;
          else                           cnt_d[i]   = cnt_q[i] + CNT_W'(1);
        end
        default: state_d[i] = ST_LO;
      endcase
    end
  end

  // Output decode from the transition about to be registered; pulses fire
  // only when a WAIT state completes qualification, never on a glitch return.
  always_comb begin
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      level_d[i]   = (state_d[i] == ST_HI) || (state_d[i] == ST_WAIT_LO);
      press_d[i]   = (state_q[i] == ST_WAIT_HI) && (state_d[i] == ST_HI);
      release_d[i] = (state_q[i] == ST_WAIT_LO) && (state_d[i] == ST_LO);
    end
  end

  assign bus.pb_level   = level_q;
  assign bus.pb_press   = press_q;
  assign bus.pb_release = release_q;

endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce with N=5, STABLE_CYCLES=4.
module tb_pb_debounce;

  localparam int unsigned N  = 5;
  localparam int unsigned SC = 4;

  logic clk;
  logic rst_n;
  logic cmp_en;
  int   checks;
  int   failures;

  pb_debounce_if #(.N(N)) bus ();

  pb_debounce #(
    .N             (N),
    .STABLE_CYCLES (SC),
    .CNT_W         (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Time-based model: a channel's accepted level flips once the value seen
  // through the 2-clock synchronizer delay has differed from it on every edge
  // from its first appearance up to SC edges later.
  logic [N-1:0] d1, d2, m_level, m_press, m_rel, pend;
  int           start [N];
  int           edge_no;

  initial begin
    d1 = '0; d2 = '0; m_level = '0; m_press = '0; m_rel = '0; pend = '0;
    edge_no = 0;
    for (int i = 0; i < int'(N); i++) start[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        d1 = '0; d2 = '0; m_level = '0; m_press = '0; m_rel = '0; pend = '0;
        edge_no = 0;
      end else begin
        edge_no++;
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < int'(N); i++) begin
          if (d2[i] == m_level[i]) begin
            pend[i] = 1'b0;
          end else if (!pend[i]) begin
            pend[i]  = 1'b1;
            start[i] = edge_no;
          end else if (edge_no - start[i] == int'(SC)) begin
            m_level[i] = d2[i];
            pend[i]    = 1'b0;
            if (d2[i]) m_press[i] = 1'b1;
            else       m_rel[i]   = 1'b1;
          end
        end
        d2 = d1;
        d1 = bus.pb_in;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("cyc_level",   bus.pb_level,   m_level);
        chk("cyc_press",   bus.pb_press,   m_press);
        chk("cyc_release", bus.pb_release, m_rel);
        chk("cyc_exclusive", bus.pb_press & bus.pb_release, 5'b00000);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b1;
    bus.pb_in = '0;
    #2;
    rst_n  = 1'b0;
    cmp_en = 1'b1;

    // Buttons held through reset release.
    bus.pb_in = 5'b11111;
    repeat (3) step();
    chk("rst_level",   bus.pb_level,   5'b00000);
    chk("rst_press",   bus.pb_press,   5'b00000);
    chk("rst_release", bus.pb_release, 5'b00000);
    rst_n = 1'b1;
    repeat (6) step();
    chk("rst_hold_e6_level", bus.pb_level, 5'b00000);
    step();
    chk("rst_hold_e7_level", bus.pb_level, 5'b11111);
    chk("rst_hold_e7_press", bus.pb_press, 5'b11111);
    step();
    chk("rst_hold_e8_press", bus.pb_press, 5'b00000);
    chk("rst_hold_e8_level", bus.pb_level, 5'b11111);

    // Settle everything low.
    bus.pb_in = 5'b00000;
    repeat (12) step();
    chk("settle_low", bus.pb_level, 5'b00000);

    // Clean press on channel 0.
    bus.pb_in = 5'b00001;
    repeat (6) step();
    chk("press0_e6_level", bus.pb_level, 5'b00000);
    step();
    chk("press0_e7_level", bus.pb_level, 5'b00001);
    chk("press0_e7_press", bus.pb_press, 5'b00001);
    step();
    chk("press0_e8_press", bus.pb_press, 5'b00000);

    // Bounce on channel 2: 1,0,1,0 for 3 clocks each, then hold 1.
    for (int k = 0; k < 4; k++) begin
      bus.pb_in[2] = (k % 2 == 0) ? 1'b1 : 1'b0;
      repeat (3) begin
        step();
        chk("bounce_level", bus.pb_level, 5'b00001);
        chk("bounce_press", bus.pb_press, 5'b00000);
      end
    end
    bus.pb_in[2] = 1'b1;
    repeat (6) step();
    chk("bounce_e6_level", bus.pb_level, 5'b00001);
    step();
    chk("bounce_e7_level", bus.pb_level, 5'b00101);
    chk("bounce_e7_press", bus.pb_press, 5'b00100);

    // Release on channel 1 with short glitches first.
    bus.pb_in[1] = 1'b1;
    repeat (10) step();
    chk("rel_setup_level", bus.pb_level, 5'b00111);
    for (int g = 1; g <= 3; g++) begin
      bus.pb_in[1] = 1'b0;
      repeat (g) begin
        step();
        chk("glitch_release", bus.pb_release, 5'b00000);
      end
      bus.pb_in[1] = 1'b1;
      repeat (5) begin
        step();
        chk("glitch_release", bus.pb_release, 5'b00000);
        chk("glitch_level",   bus.pb_level,   5'b00111);
      end
    end
    bus.pb_in[1] = 1'b0;
    repeat (6) step();
    chk("rel1_e6_level", bus.pb_level, 5'b00111);
    step();
    chk("rel1_e7_level",   bus.pb_level,   5'b00101);
    chk("rel1_e7_release", bus.pb_release, 5'b00010);
    step();
    chk("rel1_e8_release", bus.pb_release, 5'b00000);

    // Channels 3 and 4 together.
    bus.pb_in = 5'b11101;
    repeat (6) step();
    chk("simul_e6_level", bus.pb_level, 5'b00101);
    step();
    chk("simul_e7_level", bus.pb_level, 5'b11101);
    chk("simul_e7_press", bus.pb_press, 5'b11000);

    // Mid-count reset on channel 0 (WAIT_HI, cnt=2 after 5 edges).
    bus.pb_in[0] = 1'b0;
    repeat (10) step();
    chk("mid_setup_level", bus.pb_level, 5'b11100);
    bus.pb_in[0] = 1'b1;
    repeat (5) step();
    chk("mid_pre_level", bus.pb_level, 5'b11100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level",   bus.pb_level,   5'b00000);
    chk("mid_rst_press",   bus.pb_press,   5'b00000);
    chk("mid_rst_release", bus.pb_release, 5'b00000);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("mid_e6_level", bus.pb_level, 5'b00000);
    step();
    chk("mid_e7_level", bus.pb_level, 5'b11101);
    chk("mid_e7_press", bus.pb_press, 5'b11101);
    step();
    chk("mid_e8_press", bus.pb_press, 5'b00000);

    repeat (2) step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
